// File: rtl/alu_multicycle.sv
// alu_multicycle: ALU with registered result and flags.
// Logic and arithmetic opcodes complete in one cycle. Shifts by s>0 run one bit
// per cycle through an internal register. Define ALU_BARREL_EN to replace the
// iterative shifter with a single-cycle barrel shifter; busy_o then stays 0.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       operacion_i,
  output logic [WIDTH-1:0] resultado_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             zero_o,
  output logic             c_o,
  output logic             ovf_o
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t r_state, w_state_nxt;

  // Shift engine registers (operand copy, remaining shifts, latched opcode)
  logic [WIDTH-1:0] r_sh, w_sh_nxt;
  logic [SHW-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]       r_op, w_op_nxt;

  // Output registers
  logic [WIDTH-1:0] r_res, w_res_nxt;
  logic             r_zero, w_zero_nxt;
  logic             r_c, w_c_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  // Single-cycle datapath
  logic [SHW-1:0]   w_shamt;
  logic             w_is_shift;
  logic             w_iter_shift;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic             w_slt;
  logic             w_sltu;
  logic [WIDTH-1:0] w_shift_imm;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_ovf;
  logic [WIDTH-1:0] w_first;
  logic [WIDTH-1:0] w_step;

  // One-bit shift step; the opcode selects fill direction and fill value
  function automatic logic [WIDTH-1:0] f_shift1(input logic [WIDTH-1:0] v,
                                                 input logic [3:0]       op);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
      OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = {1'b0, v[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  assign w_shamt    = b_i[SHW-1:0];
  assign w_is_shift = (operacion_i == OP_SRL) || (operacion_i == OP_SLL) ||
                      (operacion_i == OP_SRA);

  // Adder and subtractor share the carry/overflow rules: SUB is a + ~b + 1
  assign w_add     = {1'b0, a_i} + {1'b0, b_i};
  assign w_sub     = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
  assign w_add_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                     (w_add[WIDTH-1] != a_i[WIDTH-1]);
  assign w_sub_ovf = (a_i[WIDTH-1] == ~b_i[WIDTH-1]) &&
                     (w_sub[WIDTH-1] != a_i[WIDTH-1]);
  assign w_slt     = w_sub[WIDTH-1] ^ w_sub_ovf;
  assign w_sltu    = ~w_sub[WIDTH];

`ifdef ALU_BARREL_EN
  // Barrel shifter: every shift amount finishes in the accepting cycle
  assign w_iter_shift = 1'b0;

  // Combinational barrel shift of the live operand
  always_comb begin
    w_shift_imm = a_i >> w_shamt;
    case (operacion_i)
      OP_SLL:  w_shift_imm = a_i << w_shamt;
      OP_SRA:  w_shift_imm = $signed(a_i) >>> w_shamt;
      default: w_shift_imm = a_i >> w_shamt;
    endcase
  end
`else
  // Iterative shifter: only a zero shift amount completes immediately
  assign w_iter_shift = w_is_shift && (w_shamt != '0);
  assign w_shift_imm  = a_i;
`endif

  // Result and flags for operations that finish in the accepting cycle
  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_ovf = 1'b0;
    if (w_is_shift) begin
      w_alu_res = w_shift_imm;
    end else begin
      case (operacion_i)
        OP_AND:  w_alu_res = a_i & b_i;
        OP_OR:   w_alu_res = a_i | b_i;
        OP_XOR:  w_alu_res = a_i ^ b_i;
        OP_ADD: begin
          w_alu_res = w_add[WIDTH-1:0];
          w_alu_c   = w_add[WIDTH];
          w_alu_ovf = w_add_ovf;
        end
        OP_SUB: begin
          w_alu_res = w_sub[WIDTH-1:0];
          w_alu_c   = w_sub[WIDTH];
          w_alu_ovf = w_sub_ovf;
        end
        OP_SLT:  w_alu_res = WIDTH'(w_slt);
        OP_SLTU: w_alu_res = WIDTH'(w_sltu);
        default: w_alu_res = '0;
      endcase
    end
  end

  assign w_first = f_shift1(a_i, operacion_i);
  assign w_step  = f_shift1(r_sh, r_op);

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_res_nxt   = r_res;
    w_zero_nxt  = r_zero;
    w_c_nxt     = r_c;
    w_ovf_nxt   = r_ovf;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          if (w_iter_shift) begin
            // The accepting edge already performs the first shift
            w_op_nxt  = operacion_i;
            w_sh_nxt  = w_first;
            w_cnt_nxt = w_shamt - SHW'(1);
            if (w_shamt == SHW'(1)) begin
              w_res_nxt  = w_first;
              w_zero_nxt = (w_first == '0);
              w_c_nxt    = 1'b0;
              w_ovf_nxt  = 1'b0;
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = SHIFT;
              w_busy_nxt  = 1'b1;
            end
          end else begin
            w_res_nxt  = w_alu_res;
            w_zero_nxt = (w_alu_res == '0);
            w_c_nxt    = w_alu_c;
            w_ovf_nxt  = w_alu_ovf;
            w_done_nxt = 1'b1;
          end
        end
      end
      SHIFT: begin
        // start_i is deliberately not looked at here: no queueing
        w_sh_nxt  = w_step;
        w_cnt_nxt = r_cnt - SHW'(1);
        if (r_cnt == SHW'(1)) begin
          w_state_nxt = IDLE;
          w_res_nxt   = w_step;
          w_zero_nxt  = (w_step == '0);
          w_c_nxt     = 1'b0;
          w_ovf_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_busy_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shift engine and output registers; reset aborts any shift in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_op   <= '0;
      r_res  <= '0;
      r_zero <= 1'b0;
      r_c    <= 1'b0;
      r_ovf  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_sh   <= w_sh_nxt;
      r_cnt  <= w_cnt_nxt;
      r_op   <= w_op_nxt;
      r_res  <= w_res_nxt;
      r_zero <= w_zero_nxt;
      r_c    <= w_c_nxt;
      r_ovf  <= w_ovf_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign resultado_o = r_res;
  assign zero_o      = r_zero;
  assign c_o         = r_c;
  assign ovf_o       = r_ovf;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

endmodule

// File: tb/tb_alu_multicycle.sv
// Testbench for alu_multicycle (WIDTH=32): randomized and directed operations
// checked against an arithmetic reference model. Honours ALU_BARREL_EN.
module tb_alu_multicycle;

`ifdef ALU_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [3:0]  operacion_i = '0;
  logic [31:0] resultado_o;
  logic        busy_o, done_o, zero_o, c_o, ovf_o;

  int n_pass = 0;
  int n_checks = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .a_i(a_i), .b_i(b_i),
    .operacion_i(operacion_i), .resultado_o(resultado_o), .busy_o(busy_o),
    .done_o(done_o), .zero_o(zero_o), .c_o(c_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference model from the opcode definitions, using plain wide arithmetic
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic c, output logic ov);
    longint sa, sb, t;
    logic [32:0] wide;
    int s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = int'(b[4:0]);
    r  = '0; c = 1'b0; ov = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0100: r = a ^ b;
      4'b0010: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[31:0]; c = wide[32];
        t = sa + sb;
        ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'b0110: begin
        r = a - b; c = (a >= b);
        t = sa - sb;
        ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'b0011: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b0101: r = (a < b) ? 32'd1 : 32'd0;
      4'b0111: r = a >> s;
      4'b1000: r = a << s;
      4'b1001: r = $signed(a) >>> s;
      default: r = '0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    if (!BARREL && (op == 4'b0111 || op == 4'b1000 || op == 4'b1001) && s != 0)
      return s;
    return 1;
  endfunction

  // Issue one request, scramble the inputs after acceptance, wait for done_o
  task automatic issue_and_wait(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output int lat, output int nbusy);
    @(negedge clk_i);
    start_i = 1'b1; operacion_i = op; a_i = a; b_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0; a_i = $urandom; b_i = $urandom; operacion_i = 4'($urandom);
    lat = 1; nbusy = 0;
    while (done_o !== 1'b1 && lat < 80) begin
      if (busy_o === 1'b1) nbusy++;
      @(posedge clk_i); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++; if (resultado_o !== 32'd0) $display("FAIL reset_res: got %h expected 0", resultado_o); else n_pass++;
    n_checks++; if ({zero_o, c_o, ovf_o} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {zero_o, c_o, ovf_o}); else n_pass++;
    n_checks++; if ({busy_o, done_o} !== 2'b00) $display("FAIL reset_busy_done: got %b expected 00", {busy_o, done_o}); else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_arith_flags();
    logic [3:0]  ops [10] = '{4'b0010, 4'b0110, 4'b0011, 4'b0101, 4'b0010,
                              4'b0110, 4'b0000, 4'b0100, 4'b1111, 4'b1011};
    logic [31:0] as  [10] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h80000000,
                              32'h7FFFFFFF, 32'd5, 32'hF0F0F0F0, 32'h12345678,
                              32'hDEADBEEF, 32'h1};
    logic [31:0] bs  [10] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd5,
                              32'h0F0F0F0F, 32'h12345678, 32'h1, 32'h2};
    logic [31:0] er;
    logic ec, eo;
    int lat, nb;
    for (int i = 0; i < 10; i++) begin
      ref_model(ops[i], as[i], bs[i], er, ec, eo);
      issue_and_wait(ops[i], as[i], bs[i], lat, nb);
      n_checks++; if (lat !== 1) $display("FAIL arith_lat[%0d]: got %0d expected 1", i, lat); else n_pass++;
      n_checks++; if (resultado_o !== er) $display("FAIL arith_res[%0d] op=%b: got %h expected %h", i, ops[i], resultado_o, er); else n_pass++;
      n_checks++; if ({zero_o, c_o, ovf_o} !== {(er == 32'd0), ec, eo})
        $display("FAIL arith_flags[%0d] op=%b: got zco=%b expected %b", i, ops[i], {zero_o, c_o, ovf_o}, {(er == 32'd0), ec, eo}); else n_pass++;
      @(posedge clk_i); #1;
      n_checks++; if (done_o !== 1'b0) $display("FAIL arith_done_pulse[%0d]: got %b expected 0", i, done_o); else n_pass++;
      n_checks++; if (resultado_o !== er) $display("FAIL arith_hold[%0d]: got %h expected %h", i, resultado_o, er); else n_pass++;
    end
  endtask

  task automatic test_shift_directed();
    logic [3:0]  ops [4] = '{4'b1000, 4'b0111, 4'b1001, 4'b0111};
    logic [31:0] as  [4] = '{32'h1, 32'hCAFEF00D, 32'h80000001, 32'h80000000};
    logic [31:0] bs  [4] = '{32'd31, 32'hFFFFFFE0, 32'd1, 32'd2};
    logic [31:0] er;
    logic ec, eo;
    int lat, nb, el;
    for (int i = 0; i < 4; i++) begin
      ref_model(ops[i], as[i], bs[i], er, ec, eo);
      el = ref_latency(ops[i], bs[i]);
      issue_and_wait(ops[i], as[i], bs[i], lat, nb);
      n_checks++; if (lat !== el) $display("FAIL shift_lat[%0d]: got %0d expected %0d", i, lat, el); else n_pass++;
      n_checks++; if (nb !== el - 1) $display("FAIL shift_busy[%0d]: got %0d expected %0d", i, nb, el - 1); else n_pass++;
      n_checks++; if (resultado_o !== er) $display("FAIL shift_res[%0d]: got %h expected %h", i, resultado_o, er); else n_pass++;
      n_checks++; if ({zero_o, c_o, ovf_o} !== {(er == 32'd0), 2'b00})
        $display("FAIL shift_flags[%0d]: got %b expected %b", i, {zero_o, c_o, ovf_o}, {(er == 32'd0), 2'b00}); else n_pass++;
    end
  endtask

  task automatic test_busy_ignore();
    int lat, nb, el;
    el = BARREL ? 1 : 4;
    @(negedge clk_i);
    start_i = 1'b1; operacion_i = 4'b1001; a_i = 32'hF0000000; b_i = 32'd4;
    @(posedge clk_i); #1;
    operacion_i = 4'b0010; a_i = 32'd1; b_i = 32'd1;
    lat = 1; nb = 0;
    while (done_o !== 1'b1 && lat < 80) begin
      if (busy_o === 1'b1) nb++;
      @(posedge clk_i); #1;
      lat++;
    end
    start_i = 1'b0;
    n_checks++; if (lat !== el) $display("FAIL busy_ign_lat: got %0d expected %0d", lat, el); else n_pass++;
    n_checks++; if (nb !== el - 1) $display("FAIL busy_ign_busy: got %0d expected %0d", nb, el - 1); else n_pass++;
    n_checks++; if (resultado_o !== 32'hFF000000) $display("FAIL busy_ign_res: got %h expected ff000000", resultado_o); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #1;
      n_checks++; if ({done_o, busy_o} !== 2'b00 || resultado_o !== 32'hFF000000)
        $display("FAIL busy_ign_noqueue[%0d]: got done=%b busy=%b res=%h expected 0 0 ff000000", k, done_o, busy_o, resultado_o); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pool [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0011,
                             4'b0101, 4'b0100, 4'b1100, 4'b1111};
    logic [3:0]  op;
    logic [31:0] a, b, er;
    logic ec, eo;
    @(negedge clk_i);
    op = pool[$urandom_range(0, 8)]; a = $urandom; b = $urandom;
    start_i = 1'b1; operacion_i = op; a_i = a; b_i = b;
    for (int k = 0; k < 8; k++) begin
      ref_model(op, a, b, er, ec, eo);
      @(posedge clk_i); #1;
      n_checks++; if (done_o !== 1'b1 || resultado_o !== er || {c_o, ovf_o} !== {ec, eo})
        $display("FAIL b2b[%0d] op=%b: got done=%b res=%h co=%b expected 1 %h %b", k, op, done_o, resultado_o, {c_o, ovf_o}, er, {ec, eo}); else n_pass++;
      op = pool[$urandom_range(0, 8)]; a = $urandom; b = $urandom;
      operacion_i = op; a_i = a; b_i = b;
    end
    start_i = 1'b0;
    @(posedge clk_i); #1;
    n_checks++; if (done_o !== 1'b0) $display("FAIL b2b_idle_done: got %b expected 0", done_o); else n_pass++;
  endtask

  task automatic test_reset_midshift();
    @(negedge clk_i);
    start_i = 1'b1; operacion_i = 4'b0111; a_i = 32'h8765_4321; b_i = 32'd20;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    n_checks++; if (resultado_o !== 32'd0) $display("FAIL rst_mid_res: got %h expected 0", resultado_o); else n_pass++;
    n_checks++; if ({zero_o, c_o, ovf_o, busy_o, done_o} !== 5'b0)
      $display("FAIL rst_mid_outs: got %b expected 00000", {zero_o, c_o, ovf_o, busy_o, done_o}); else n_pass++;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_i); #1;
      if (k == 19) rst_i = 1'b0;
      n_checks++; if (done_o !== 1'b0 || busy_o !== 1'b0)
        $display("FAIL rst_mid_nodone[%0d]: got done=%b busy=%b expected 0 0", k, done_o, busy_o); else n_pass++;
    end
    @(negedge clk_i);
    start_i = 1'b1; operacion_i = 4'b0010; a_i = 32'd3; b_i = 32'd4;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n_checks++; if (done_o !== 1'b1 || resultado_o !== 32'd7)
      $display("FAIL rst_after_add: got done=%b res=%h expected 1 00000007", done_o, resultado_o); else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b, er;
    logic ec, eo;
    int lat, nb, el;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (i % 3 == 0) b = 32'($urandom_range(0, 5));
      ref_model(op, a, b, er, ec, eo);
      el = ref_latency(op, b);
      issue_and_wait(op, a, b, lat, nb);
      n_checks++; if (lat !== el || nb !== el - 1)
        $display("FAIL rand_timing[%0d] op=%b b=%h: got lat=%0d busy=%0d expected %0d %0d", i, op, b, lat, nb, el, el - 1); else n_pass++;
      n_checks++; if (resultado_o !== er)
        $display("FAIL rand_res[%0d] op=%b a=%h b=%h: got %h expected %h", i, op, a, b, resultado_o, er); else n_pass++;
      n_checks++; if ({zero_o, c_o, ovf_o} !== {(er == 32'd0), ec, eo})
        $display("FAIL rand_flags[%0d] op=%b a=%h b=%h: got %b expected %b", i, op, a, b, {zero_o, c_o, ovf_o}, {(er == 32'd0), ec, eo}); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_arith_flags();
    test_shift_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midshift();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits (legal values 8..64).
REQ-002 The module SHALL have parameter SHW, default $clog2(WIDTH), meaning the shift-amount field width.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset; asynchronous and active-high.
REQ-005 start_i  input  1  request strobe; accepted only while busy_o=0.
REQ-006 a_i  input  WIDTH  operand A.
REQ-007 b_i  input  WIDTH  operand B; its low SHW bits are the shift amount for shift operations.
REQ-008 operacion_i  input  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 SLT, 0101 SLTU, 0100 XOR, 0111 SRL, 1000 SLL, 1001 SRA.
REQ-009 resultado_o  output  WIDTH  registered result.
REQ-010 busy_o  output  1  high while an operation is in progress.
REQ-011 done_o  output  1  one-cycle pulse when resultado_o and the flags update.
REQ-012 zero_o, c_o, ovf_o  output  1 each  registered flags: result==0, carry-out, signed overflow.

Function
REQ-013 On an accepted start_i, the block SHALL latch a_i, b_i and operacion_i; later input changes SHALL NOT affect the operation.
REQ-014 The FSM SHALL have states IDLE and SHIFT; busy_o SHALL equal 1 only in SHIFT.
REQ-015 Non-shift opcodes SHALL complete in IDLE: result, flags and done_o=1 SHALL be registered at the same edge that accepts start_i (latency 1 cycle).
REQ-016 ADD SHALL compute a+b mod 2^WIDTH with c_o = carry-out of bit WIDTH-1.
REQ-017 SUB SHALL compute a+~b+1 with c_o = carry-out of that sum (1 = no borrow).
REQ-018 ovf_o SHALL be 1 for ADD/SUB when the operand signs (after B inversion for SUB) match and the result sign differs; otherwise 0.
REQ-019 SLT SHALL return 1 in bit 0 (other bits 0) when a<b signed, using sum-sign XOR overflow of a-b; SLTU SHALL do the same unsigned (result 1 when the SUB carry is 0).
REQ-020 AND/OR/XOR/SLT/SLTU/shift opcodes SHALL drive c_o=0 and ovf_o=0.
REQ-021 zero_o SHALL be 1 exactly when the registered resultado_o is all zeros, for every opcode.
REQ-022 Shift opcodes with shift amount s=0 SHALL complete like non-shift opcodes (1 cycle, result = a).
REQ-023 Shift opcodes with s>0 SHALL load a into an internal register, enter SHIFT, shift by exactly one bit per cycle, and SHALL assert done_o and return to IDLE at the edge that performs the s-th shift (total latency s cycles after acceptance, busy_o high for s-1 cycles).
REQ-024 SRL SHALL fill with 0 from the MSB, SLL SHALL fill with 0 from the LSB, SRA SHALL replicate the sign bit of the latched a.
REQ-025 start_i asserted while busy_o=1 SHALL be ignored, with no queueing.
REQ-026 start_i asserted in the same cycle that done_o is asserted from SHIFT SHALL be ignored; the next request is accepted only once busy_o=0.
REQ-027 Undefined opcodes SHALL complete in 1 cycle with resultado_o=0, zero_o=1, c_o=0, ovf_o=0.
REQ-028 resultado_o and the flags SHALL hold their last value until the next completion; done_o SHALL be 0 in every other cycle.

Reset
REQ-029 rst_i=1 SHALL immediately force state IDLE, resultado_o=0, zero_o=0, c_o=0, ovf_o=0, busy_o=0 and done_o=0, including mid-shift; an aborted operation SHALL never assert done_o.
REQ-030 The first start_i SHALL be accepted at the first rising edge after rst_i deasserts.

Configuration
REQ-031 With macro ALU_BARREL_EN defined, all shift opcodes SHALL complete in 1 cycle through a combinational barrel shifter, and busy_o SHALL be constantly 0.
REQ-032 Without ALU_BARREL_EN, shifts SHALL use the iterative behaviour of REQ-023; results SHALL be bit-identical in both builds.

Verification
REQ-033 WIDTH=32, ADD a=0xFFFFFFFF, b=1 -> result 0 with zero_o=1, c_o=1, ovf_o=0, done_o high one cycle after start.
REQ-034 SUB a=0x80000000, b=1 -> result 0x7FFFFFFF with ovf_o=1, c_o=1; SLT with the same operands -> 1; SLTU with the same operands -> 0.
REQ-035 SRA a=0xF0000000, b=4 (iterative build) -> busy_o high 3 cycles, done_o on cycle 4, result 0xFF000000; a second start_i held during busy is ignored.
REQ-036 SLL a=1, b=31 -> result 0x80000000 after 31 cycles; SRL with b=0 -> result a in 1 cycle.
REQ-037 rst_i pulsed mid-SRL with b=20 at cycle 5 -> all outputs 0 immediately, no done_o; a new ADD issued after reset completes normally.
REQ-038 Repeat REQ-035 and REQ-036 with ALU_BARREL_EN defined -> identical results, all with 1-cycle latency and busy_o never high.
